// File: rtl/uint16_calc_keypad_controller_pkg.sv
// Shared types for the keypad front end of the 16-bit calculator:
// key codes, controller states and the one-hot operation encoding.
package uint16_calc_keypad_controller_pkg;

   typedef logic [3:0] KeyCode;

   localparam KeyCode KEY_ADD = 4'd10;
   localparam KeyCode KEY_SUB = 4'd11;
   localparam KeyCode KEY_MUL = 4'd12;
   localparam KeyCode KEY_DIV = 4'd13;
   localparam KeyCode KEY_EQ  = 4'd14;
   localparam KeyCode KEY_CLR = 4'd15;

   typedef enum logic [1:0] {ENTER_A, ENTER_B, EXEC, ERROR} CalcState;

   // Bit order {add, subtract, divide, multiply} matches the calculator op lines.
   typedef enum logic [3:0] {
      OP_NONE = 4'b0000,
      OP_ADD  = 4'b1000,
      OP_SUB  = 4'b0100,
      OP_DIV  = 4'b0010,
      OP_MUL  = 4'b0001
   } CalcOp;

   function automatic CalcOp key_to_op(input KeyCode k);
      case (k)
         KEY_ADD: return OP_ADD;
         KEY_SUB: return OP_SUB;
         KEY_MUL: return OP_MUL;
         KEY_DIV: return OP_DIV;
         default: return OP_NONE;
      endcase
   endfunction

endpackage

// File: rtl/uint16_calc_keypad_controller_accumulator.sv
// Decimal digit entry step: acc*10 + d, evaluated 20 bits wide so that
// anything past 65535 is flagged rather than wrapped.
module uint16_decimal_accumulator (
   input  logic [15:0] acc,
   input  logic [3:0]  digit,
   output logic [15:0] next,
   output logic        overflow
);
   logic [19:0] wide;

   assign wide     = ({4'd0, acc} * 20'd10) + {16'd0, digit};
   assign next     = wide[15:0];
   assign overflow = |wide[19:16];

endmodule

// File: rtl/uint16_calc_keypad_controller.sv
// Keypad-to-calculator controller: builds operands from digit keys, issues
// one-cycle operations to the combinational calculator and holds the display.
module uint16_calc_keypad_controller
   import uint16_calc_keypad_controller_pkg::*;
#(
   parameter bit DIV_ZERO_IS_ERROR = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   output logic        key_ready,
   output logic [15:0] calc_a,
   output logic [15:0] calc_b,
   output logic        calc_add,
   output logic        calc_subtract,
   output logic        calc_divide,
   output logic        calc_multiply,
   input  logic [15:0] calc_result,
   input  logic        calc_invalid,
   output logic [15:0] display,
   output logic        error
);

   CalcState    state_q, state_d;
   CalcOp       op_q, op_d, pend_q, pend_d;
   logic [15:0] a_q, a_d, b_q, b_d, disp_q, disp_d;
   logic        fresh_q, fresh_d, bent_q, bent_d, chain_q, chain_d;

   logic        accept, is_digit, is_op, div0, do_err, do_clear, in_exec;
   logic [15:0] acc_in, acc_next;
   logic        acc_ovf;

   // A fresh A entry (after equals) restarts from zero instead of extending the result.
   assign acc_in = (state_q == ENTER_B) ? b_q : (fresh_q ? 16'd0 : a_q);

   uint16_decimal_accumulator u_acc (
      .acc      (acc_in),
      .digit    (key_code),
      .next     (acc_next),
      .overflow (acc_ovf)
   );

   assign in_exec   = (state_q == EXEC);
   assign key_ready = !in_exec;
   assign accept    = key_valid && key_ready;
   assign is_digit  = (key_code <= 4'd9);
   assign is_op     = (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
   assign div0      = DIV_ZERO_IS_ERROR && (op_q == OP_DIV) && (b_q == 16'd0);

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      pend_d   = pend_q;
      a_d      = a_q;
      b_d      = b_q;
      disp_d   = disp_q;
      fresh_d  = fresh_q;
      bent_d   = bent_q;
      chain_d  = chain_q;
      do_err   = 1'b0;
      do_clear = 1'b0;

      case (state_q)
         ENTER_A: if (accept) begin
            if (key_code == KEY_CLR) do_clear = 1'b1;
            else if (is_digit) begin
               if (acc_ovf) do_err = 1'b1;
               else begin
                  a_d     = acc_next;
                  disp_d  = acc_next;
                  fresh_d = 1'b0;
               end
            end else if (is_op) begin
               op_d    = key_to_op(key_code);
               b_d     = 16'd0;
               bent_d  = 1'b0;
               state_d = ENTER_B;
            end
         end
         ENTER_B: if (accept) begin
            if (key_code == KEY_CLR) do_clear = 1'b1;
            else if (is_digit) begin
               if (acc_ovf) do_err = 1'b1;
               else begin
                  b_d    = acc_next;
                  disp_d = acc_next;
                  bent_d = 1'b1;
               end
            end else if (is_op && !bent_q) op_d = key_to_op(key_code);
            else if (bent_q) begin
               // Op or equals with a complete B operand: execute, unless it is x/0.
               if (div0) do_err = 1'b1;
               else begin
                  chain_d = is_op;
                  pend_d  = key_to_op(key_code);
                  state_d = EXEC;
               end
            end
         end
         EXEC: begin
            if (calc_invalid) do_err = 1'b1;
            else begin
               a_d    = calc_result;
               disp_d = calc_result;
               if (chain_q) begin
                  op_d    = pend_q;
                  b_d     = 16'd0;
                  bent_d  = 1'b0;
                  state_d = ENTER_B;
               end else begin
                  fresh_d = 1'b1;
                  state_d = ENTER_A;
               end
            end
         end
         ERROR: if (accept && (key_code == KEY_CLR)) do_clear = 1'b1;
         default: state_d = ENTER_A;
      endcase

      if (do_err) begin
         state_d = ERROR;
         disp_d  = 16'd0;
      end
      if (do_clear) begin
         state_d = ENTER_A;
         op_d    = OP_NONE;
         pend_d  = OP_NONE;
         a_d     = 16'd0;
         b_d     = 16'd0;
         disp_d  = 16'd0;
         fresh_d = 1'b0;
         bent_d  = 1'b0;
         chain_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ENTER_A;
         op_q    <= OP_NONE;
         pend_q  <= OP_NONE;
         a_q     <= 16'd0;
         b_q     <= 16'd0;
         disp_q  <= 16'd0;
         fresh_q <= 1'b0;
         bent_q  <= 1'b0;
         chain_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         pend_q  <= pend_d;
         a_q     <= a_d;
         b_q     <= b_d;
         disp_q  <= disp_d;
         fresh_q <= fresh_d;
         bent_q  <= bent_d;
         chain_q <= chain_d;
      end
   end

   assign calc_a        = in_exec ? a_q : 16'd0;
   assign calc_b        = in_exec ? b_q : 16'd0;
   assign calc_add      = in_exec && op_q[3];
   assign calc_subtract = in_exec && op_q[2];
   assign calc_divide   = in_exec && op_q[1];
   assign calc_multiply = in_exec && op_q[0];
   assign display       = disp_q;
   assign error         = (state_q == ERROR);

endmodule
